// File: rtl/tank_ctrl.sv
// Per-player tank controller: terrain-following movement, press-triggered aim,
// fire/reload handshake with the projectile block, and hit-point tracking.
module tank_ctrl #(
  parameter int unsigned X_START       = 500,
  parameter int unsigned X_MIN         = 4,
  parameter int unsigned X_MAX         = 635,
  parameter int unsigned X_STEP        = 1,
  parameter int unsigned TANK_SIZE     = 4,
  parameter int unsigned Y_OFFSET      = 45,
  parameter int unsigned AIM_W         = 6,
  parameter int unsigned AIM_MAX       = 30,
  parameter int unsigned AIM_STEP      = 3,
  parameter int unsigned HP_W          = 4,
  parameter int unsigned HP_INIT       = 10,
  parameter int unsigned RELOAD_FRAMES = 60,
  parameter logic [7:0]  KEY_LEFT      = 8'h0d,
  parameter logic [7:0]  KEY_RIGHT     = 8'h0f,
  parameter logic [7:0]  KEY_UP        = 8'h0c,
  parameter logic [7:0]  KEY_DOWN      = 8'h0e,
  parameter logic [7:0]  KEY_FIRE      = 8'h28,
  parameter logic [7:0]  KEY_RELOAD    = 8'h13
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic [7:0]      keycode,
  input  logic [9:0]      terrain_y,
  input  logic            hit,
  input  logic [HP_W-1:0] damage,
  input  logic            shot_ack,
  output logic [9:0]      TankX,
  output logic [9:0]      TankY,
  output logic [9:0]      TankS,
  output logic [1:0]      Direction,
  output logic [AIM_W-1:0] aim,
  output logic            shoot,
  output logic            loaded,
  output logic [HP_W-1:0] HP,
  output logic            dead
);

  typedef enum logic [1:0] {
    ST_READY,
    ST_FIRING,
    ST_RELOADING,
    ST_DEAD
  } state_e;

  localparam int unsigned CNT_W = (RELOAD_FRAMES > 1) ? $clog2(RELOAD_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELOAD_FRAMES - 1);

  localparam logic [10:0] X_LO_LIM  = 11'(X_MIN + X_STEP);
  localparam logic [10:0] X_MAX_V   = 11'(X_MAX);
  localparam logic [10:0] X_STEP_V  = 11'(X_STEP);
  localparam logic [9:0]  X_MIN_V   = 10'(X_MIN);
  localparam logic [9:0]  X_START_V = 10'(X_START);
  localparam logic [9:0]  Y_OFF_V   = 10'(Y_OFFSET);
  localparam logic [AIM_W:0]  AIM_STEP_V = (AIM_W+1)'(AIM_STEP);
  localparam logic [AIM_W:0]  AIM_MAX_V  = (AIM_W+1)'(AIM_MAX);
  localparam logic [HP_W-1:0] HP_INIT_V  = HP_W'(HP_INIT);

  state_e           state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [1:0]       dir_q, dir_d;
  logic [AIM_W-1:0] aim_q, aim_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       prev_key_q;
  logic             shoot_q, loaded_q, dead_q;

  logic             press_up, press_down, press_fire, press_reload;
  logic             alive;
  logic [HP_W-1:0]  hp_after;
  logic [AIM_W:0]   aim_up;
  logic [10:0]      x_up;

  assign press_up     = (keycode == KEY_UP)     && (prev_key_q != KEY_UP);
  assign press_down   = (keycode == KEY_DOWN)   && (prev_key_q != KEY_DOWN);
  assign press_fire   = (keycode == KEY_FIRE)   && (prev_key_q != KEY_FIRE);
  assign press_reload = (keycode == KEY_RELOAD) && (prev_key_q != KEY_RELOAD);

  assign alive    = (state_q != ST_DEAD);
  assign hp_after = (hp_q >= damage) ? hp_q - damage : '0;
  assign aim_up   = {1'b0, aim_q} + AIM_STEP_V;
  assign x_up     = {1'b0, x_q} + X_STEP_V;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through this block can infer a latch.
    state_d = state_q;
    x_d     = x_q;
    dir_d   = dir_q;
    aim_d   = aim_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    y_d     = (terrain_y >= Y_OFF_V) ? terrain_y - Y_OFF_V : '0;

    if (alive) begin
      if (keycode == KEY_LEFT) begin
        dir_d = 2'd0;
        x_d   = ({1'b0, x_q} >= X_LO_LIM) ? x_q - X_STEP_V[9:0] : X_MIN_V;
      end else if (keycode == KEY_RIGHT) begin
        dir_d = 2'd1;
        x_d   = (x_up <= X_MAX_V) ? x_up[9:0] : X_MAX_V[9:0];
      end

      if (press_up) begin
        aim_d = (aim_up > AIM_MAX_V) ? AIM_MAX_V[AIM_W-1:0] : aim_up[AIM_W-1:0];
      end else if (press_down) begin
        aim_d = ({1'b0, aim_q} >= AIM_STEP_V) ? aim_q - AIM_STEP_V[AIM_W-1:0] : '0;
      end
    end

    unique case (state_q)
      ST_READY: begin
        if (press_fire) state_d = ST_FIRING;
      end
      ST_FIRING: begin
        if (shot_ack) begin
          state_d = ST_RELOADING;
          cnt_d   = CNT_LAST;
        end
      end
      ST_RELOADING: begin
        if (press_reload || cnt_q == '0) state_d = ST_READY;
        else                             cnt_d   = cnt_q - 1'b1;
      end
      ST_DEAD: ;
      default: state_d = ST_READY;
    endcase

    // Damage is resolved last so a lethal hit overrides any fire transition.
    if (alive && hit) begin
      hp_d = hp_after;
      if (hp_after == '0) state_d = ST_DEAD;
    end
  end

  always_ff @(posedge frame_clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (!Reset) begin
      state_q    <= ST_READY;
      x_q        <= X_START_V;
      y_q        <= '0;
      dir_q      <= 2'd0;
      aim_q      <= '0;
      hp_q       <= HP_INIT_V;
      cnt_q      <= '0;
      prev_key_q <= 8'h00;
      shoot_q    <= 1'b0;
      loaded_q   <= 1'b1;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      aim_q      <= aim_d;
      hp_q       <= hp_d;
      cnt_q      <= cnt_d;
      prev_key_q <= keycode;
      shoot_q    <= (state_d == ST_FIRING);
      loaded_q   <= (state_d == ST_READY);
      dead_q     <= (state_d == ST_DEAD);
    end
  end

  assign TankX     = x_q;
  assign TankY     = y_q;
  assign TankS     = 10'(TANK_SIZE);
  assign Direction = dir_q;
  assign aim       = aim_q;
  assign shoot     = shoot_q;
  assign loaded    = loaded_q;
  assign HP        = hp_q;
  assign dead      = dead_q;

endmodule
